// File: rtl/crc_frame_gen.sv
// Framed word pass-through with a one-stage output register. It accumulates a
// parametrised MSB-first CRC over each frame and appends it as trailer words.
module crc_frame_gen #(
  parameter int unsigned   DW    = 16,
  parameter int unsigned   CW    = 22,
  parameter logic [CW-1:0] POLY  = CW'(3),
  parameter logic [CW-1:0] INIT  = '0,
  parameter int unsigned   SLICE = 11
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic          in_first,
  input  logic          in_last,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_crc,
  output logic          out_last,
  input  logic          out_ready,
  output logic [CW-1:0] frame_crc,
  output logic          crc_done,
  output logic          err_sof
);

  localparam int unsigned NTRL = (CW + SLICE - 1) / SLICE;
  localparam int unsigned TW   = NTRL * SLICE;
  localparam int unsigned KW   = (NTRL > 1) ? $clog2(NTRL) : 1;

  typedef enum logic [1:0] {IDLE, DATA, TRL} state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [CW-1:0]   crc_q, crc_d;
  logic [CW-1:0]   crc_base, crc_upd;
  logic [TW-1:0]   trl_vec;
  logic [SLICE-1:0] trl_slice;
  logic            load, accept;
  logic            out_valid_d, out_crc_d, out_last_d, crc_done_d, err_sof_d;
  logic [DW-1:0]   out_data_d;
  logic [CW-1:0]   frame_crc_d;

  // Whole-word CRC update, equivalent to shifting the word in MSB first
  function automatic logic [CW-1:0] crc_apply(input logic [CW-1:0] c,
                                              input logic [DW-1:0] d);
    logic [CW-1:0] r;
    logic          fb;
    r = c;
    for (int i = int'(DW) - 1; i >= 0; i--) begin
      fb = d[i] ^ r[CW-1];
      r  = {r[CW-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
    return r;
  endfunction

  assign load     = ~out_valid | out_ready;
  assign in_ready = (state_q != TRL) & load;
  assign accept   = in_valid & in_ready;

  // A first word always starts from the seed, even when it arrives mid-frame
  assign crc_base = ((state_q == IDLE) || in_first) ? INIT : crc_q;
  assign crc_upd  = crc_apply(crc_base, in_data);
  assign trl_vec  = TW'(crc_q);

  always_comb begin
    trl_slice = '0;
    for (int unsigned i = 0; i < NTRL; i++) begin
      if (k_q == KW'(i)) trl_slice = trl_vec[i*SLICE +: SLICE];
    end
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    crc_d       = crc_q;
    out_valid_d = out_valid;
    out_data_d  = out_data;
    out_crc_d   = out_crc;
    out_last_d  = out_last;
    frame_crc_d = frame_crc;
    crc_done_d  = 1'b0;
    err_sof_d   = 1'b0;

    if (load) out_valid_d = 1'b0;

    case (state_q)
      IDLE, DATA: begin
        if (accept) begin
          crc_d       = crc_upd;
          out_valid_d = 1'b1;
          out_data_d  = in_data;
          out_crc_d   = 1'b0;
          out_last_d  = 1'b0;
          err_sof_d   = (state_q == IDLE) ? ~in_first : in_first;
          state_d     = DATA;
          if (in_last) begin
            state_d     = TRL;
            k_d         = '0;
            frame_crc_d = crc_upd;
            crc_done_d  = 1'b1;
          end
        end
      end
      TRL: begin
        if (load) begin
          out_valid_d = 1'b1;
          out_data_d  = DW'(trl_slice);
          out_crc_d   = 1'b1;
          out_last_d  = (k_q == KW'(NTRL - 1));
          k_d         = k_q + KW'(1);
          if (k_q == KW'(NTRL - 1)) begin
            state_d = IDLE;
            k_d     = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      k_q       <= '0;
      crc_q     <= INIT;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_crc   <= 1'b0;
      out_last  <= 1'b0;
      frame_crc <= INIT;
      crc_done  <= 1'b0;
      err_sof   <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      crc_q     <= crc_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      out_crc   <= out_crc_d;
      out_last  <= out_last_d;
      frame_crc <= frame_crc_d;
      crc_done  <= crc_done_d;
      err_sof   <= err_sof_d;
    end
  end

endmodule

// File: tb/tb_crc_frame_gen.sv
// Scoreboard bench for crc_frame_gen: expected output words are queued at drive
// time and compared at each output handshake. Directed and random frames are covered.
module tb_crc_frame_gen;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_first = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_crc;
  logic        out_last;
  logic        out_ready = 1'b1;
  logic [21:0] frame_crc;
  logic        crc_done;
  logic        err_sof;

  crc_frame_gen #(.DW(16), .CW(22), .POLY(22'h000003), .INIT(22'h0), .SLICE(11)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_first(in_first), .in_last(in_last),
    .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_crc(out_crc), .out_last(out_last),
    .out_ready(out_ready),
    .frame_crc(frame_crc), .crc_done(crc_done), .err_sof(err_sof)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  logic [17:0] exp_q[$];
  logic [21:0] exp_done[$];
  logic [21:0] done_q[$];
  int sof_cnt = 0;
  int rdy_mode = 0;
  int pat_i = 0;
  logic [21:0] m_crc = '0;
  logic m_inframe = 1'b0;

  // Reference CRC: shift register with feedback taps x^1 + 1
  function automatic logic [21:0] mcrc(input logic [21:0] c, input logic [15:0] d);
    logic [21:0] r;
    logic top;
    r = c;
    for (int b = 15; b >= 0; b--) begin
      top = r[21];
      r = r << 1;
      if (top != d[b]) r = r ^ 22'h000003;
    end
    return r;
  endfunction

  // out_ready: 0 always high, 1 pattern 1,0,0,1, 2 manual, 3 random
  always @(posedge clock) begin
    #1;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: begin out_ready = ((pat_i % 4) == 0) || ((pat_i % 4) == 3); pat_i++; end
      3: out_ready = 1'($urandom_range(0, 1));
      default: ;
    endcase
  end

  logic prev_stall = 1'b0;
  logic prev_rst = 1'b1;
  logic [17:0] prev_out = '0;
  logic [17:0] e;

  always @(negedge clock) begin
    if (!reset) begin
      if (crc_done) done_q.push_back(frame_crc);
      if (err_sof) sof_cnt++;
      if (prev_stall && !prev_rst) begin
        total++;
        if ({out_valid, out_last, out_crc, out_data} !== {1'b1, prev_out}) begin
          bad++;
          $display("FAIL hold: got v=%b %h need v=1 %h", out_valid, {out_last, out_crc, out_data}, prev_out);
        end
      end
      if (out_valid && !out_ready) begin
        total++;
        if (in_ready !== 1'b0) begin
          bad++;
          $display("FAIL in_ready_stall: got %b need 0", in_ready);
        end
      end
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_word: got %h need none", {out_last, out_crc, out_data});
        end else begin
          e = exp_q.pop_front();
          if ({out_last, out_crc, out_data} !== e) begin
            bad++;
            $display("FAIL out_word: got last=%b crc=%b data=%h need last=%b crc=%b data=%h",
                     out_last, out_crc, out_data, e[17], e[16], e[15:0]);
          end
        end
      end
    end
    prev_stall = out_valid && !out_ready && !reset;
    prev_out = {out_last, out_crc, out_data};
    prev_rst = reset;
  end

  // Drive one word, updating the model and queueing expected output
  task automatic xfer(input logic [15:0] d, input logic f, input logic l, output int n);
    logic [21:0] base;
    base = (!m_inframe || f) ? 22'h0 : m_crc;
    m_crc = mcrc(base, d);
    m_inframe = 1'b1;
    exp_q.push_back({2'b00, d});
    if (l) begin
      exp_q.push_back({2'b01, 5'b0, m_crc[10:0]});
      exp_q.push_back({2'b11, 5'b0, m_crc[21:11]});
      exp_done.push_back(m_crc);
      m_inframe = 1'b0;
    end
    in_valid = 1'b1; in_data = d; in_first = f; in_last = l;
    n = 0;
    @(negedge clock);
    while (!in_ready && n < 300) begin n++; @(negedge clock); end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout: got in_ready=0 need 1");
    end
    @(posedge clock); #1;
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 300) begin @(negedge clock); n++; end
    total++;
    if (exp_q.size() != 0 || out_valid) begin
      bad++;
      $display("FAIL drain: got pending=%0d need 0", exp_q.size());
    end
    repeat (2) @(negedge clock);
    @(posedge clock); #1;
  endtask

  task automatic check_done(input string name, input logic [21:0] want);
    total++;
    if (done_q.size() == 0) begin
      bad++;
      $display("FAIL %s: got no crc_done need frame_crc=%h", name, want);
    end else begin
      logic [21:0] got;
      got = done_q.pop_front();
      if (got !== want) begin
        bad++;
        $display("FAIL %s: got frame_crc=%h need %h", name, got, want);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    total++;
    if ({out_valid, out_crc, out_last, out_data} !== 19'h0) begin
      bad++; $display("FAIL reset_out: got %h need 0", {out_valid, out_crc, out_last, out_data});
    end
    total++;
    if ({crc_done, err_sof} !== 2'b00) begin
      bad++; $display("FAIL reset_pulses: got %b need 00", {crc_done, err_sof});
    end
    total++;
    if (frame_crc !== 22'h0) begin
      bad++; $display("FAIL reset_frame_crc: got %h need 0", frame_crc);
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_in_ready: got %b need 1", in_ready);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_single();
    int n;
    int s0;
    s0 = sof_cnt;
    xfer(16'h0001, 1'b1, 1'b1, n);
    drain();
    check_done("single_crc", 22'h000003);
    total++;
    if (done_q.size() != 0 || sof_cnt != s0) begin
      bad++; $display("FAIL single_pulses: got extra_done=%0d sof=%0d need 0 0", done_q.size(), sof_cnt - s0);
    end
  endtask

  task automatic test_two_word();
    int n;
    xfer(16'h0001, 1'b1, 1'b0, n);
    xfer(16'h0000, 1'b0, 1'b1, n);
    drain();
    check_done("two_word_crc", 22'h030000);
  endtask

  task automatic test_backpressure();
    int n;
    pat_i = 0;
    rdy_mode = 1;
    xfer(16'h0001, 1'b1, 1'b0, n);
    xfer(16'h0000, 1'b0, 1'b1, n);
    drain();
    rdy_mode = 0;
    repeat (2) @(posedge clock); #1;
    check_done("stall_crc", 22'h030000);
  endtask

  task automatic test_back_to_back();
    int n;
    xfer(16'h0001, 1'b1, 1'b0, n);
    xfer(16'h0000, 1'b0, 1'b1, n);
    xfer(16'h0001, 1'b1, 1'b1, n);
    total++;
    if (n != 2) begin
      bad++; $display("FAIL b2b_gap: got %0d in_ready-low cycles need 2", n);
    end
    drain();
    check_done("b2b_crc1", 22'h030000);
    check_done("b2b_crc2", 22'h000003);
  endtask

  task automatic test_sof_errors();
    int n;
    int s0;
    s0 = sof_cnt;
    xfer(16'h0001, 1'b0, 1'b1, n);
    drain();
    total++;
    if (sof_cnt - s0 != 1) begin
      bad++; $display("FAIL sof_idle: got %0d pulses need 1", sof_cnt - s0);
    end
    check_done("sof_idle_crc", 22'h000003);
    s0 = sof_cnt;
    xfer(16'h1234, 1'b1, 1'b0, n);
    xfer(16'h0001, 1'b1, 1'b1, n);
    drain();
    total++;
    if (sof_cnt - s0 != 1) begin
      bad++; $display("FAIL sof_mid: got %0d pulses need 1", sof_cnt - s0);
    end
    check_done("sof_mid_crc", 22'h000003);
  endtask

  task automatic test_reset_trailer();
    int n;
    rdy_mode = 2;
    out_ready = 1'b1;
    xfer(16'h0001, 1'b1, 1'b1, n);
    n = 0;
    while (n < 50) begin
      @(posedge clock); #1;
      if (out_valid && out_crc) break;
      n++;
    end
    out_ready = 1'b0;
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    exp_q.delete(); done_q.delete(); m_inframe = 1'b0;
    @(negedge clock);
    total++;
    if ({out_valid, out_last} !== 2'b00) begin
      bad++; $display("FAIL reset_trl: got valid=%b last=%b need 0 0", out_valid, out_last);
    end
    rdy_mode = 0;
    repeat (6) @(negedge clock);
    @(posedge clock); #1;
    xfer(16'h0001, 1'b1, 1'b1, n);
    drain();
    check_done("after_reset_crc", 22'h000003);
  endtask

  task automatic test_random();
    int n;
    int len;
    exp_done.delete();
    rdy_mode = 3;
    for (int fr = 0; fr < 6; fr++) begin
      len = $urandom_range(1, 5);
      for (int w = 0; w < len; w++)
        xfer(16'($urandom), 1'(w == 0), 1'(w == len - 1), n);
    end
    drain();
    rdy_mode = 0;
    repeat (2) @(posedge clock); #1;
    for (int fr = 0; fr < 6; fr++) check_done("random_crc", exp_done.pop_front());
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_word();
    test_backpressure();
    test_back_to_back();
    test_sof_errors();
    test_reset_trailer();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout need completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/crc_frame_gen.md
# crc_frame_gen

Parametrised CRC frame generator for DAQ readout streams: the next generation of the fixed CRC-22/16-bit accumulator. It accepts a framed word stream through a valid/ready handshake and passes every word through with one register stage. It accumulates a CRC of configurable width and polynomial over the frame, then appends the CRC as trailer words. It sits between the readout sequencer and the output FIFO and also exports the final CRC for local checking.

## Interface
Parameters:
- DW, 16, data word width (4..32)
- CW, 22, CRC width (8..32)
- POLY, 22'h000003, polynomial without the x^CW term (default x22+x1+1)
- INIT, 0, CRC seed loaded at start of frame
- SLICE, 11, CRC bits carried per trailer word, LSB-aligned, zero-padded to DW (SLICE <= DW)
- NTRL, derived, ceil(CW/SLICE) trailer words (default 2)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  input word present
- in_data  in  DW  input word
- in_first  in  1  word is first of frame
- in_last  in  1  word is last of frame
- in_ready  out  1  block accepts input this cycle
- out_valid  out  1  output register holds a word
- out_data  out  DW  output word
- out_crc  out  1  current output word is a CRC trailer word
- out_last  out  1  final trailer word of frame
- out_ready  in  1  downstream accepts output this cycle
- frame_crc  out  CW  final CRC of last completed frame
- crc_done  out  1  one-cycle pulse when frame_crc updates
- err_sof  out  1  one-cycle pulse on a framing error

## Operation
- CRC update for each accepted word is serial-equivalent and MSB first, with in_data[DW-1] as the first bit. For i = DW-1 downto 0: fb = d[i] ^ c[CW-1]; c = (c << 1) ^ (fb ? POLY : 0), truncated to CW bits. The whole word is applied in one clock.
- Accept = in_valid & in_ready. Load = output register empty or out_ready.
- in_ready = (state != TRL) & (~out_valid | out_ready).
- States:
  - IDLE: an accepted word seeds the CRC from INIT, then applies the word, and the block goes to DATA. If in_first = 0, err_sof pulses and the word is still treated as first.
  - DATA: an accepted word updates the CRC. If in_first = 1 mid-frame, err_sof pulses and the CRC reseeds from INIT before the word is applied.
  - Any accepted word with in_last = 1 goes to TRL. Its updated CRC is latched into frame_crc, crc_done pulses, and the trailer index k clears to 0. A single-word frame with first and last set is legal.
  - TRL: on each load, out_data = {zeros, crc[k*SLICE +: SLICE]}, with bits at or above CW zero-filled. out_crc = 1, out_last = (k == NTRL-1), and k increments. After loading the last trailer word, the block returns to IDLE.
- Passed-through data words have out_crc = 0 and out_last = 0.
- Output holds stable while out_valid & ~out_ready. out_valid clears on handshake when no new load occurs.

## Timing
- Reset values:
  - out_valid, out_data, out_crc, out_last, crc_done, err_sof = 0
  - frame_crc = INIT
  - state IDLE, k = 0, running CRC = INIT
  - in_ready = 1 in the first cycle after reset.
- Latency: a word accepted at edge N is on out_data from edge N to N+1. The running CRC updates at the same edge.
- Final CRC: frame_crc and crc_done are valid in the cycle after the in_last word is accepted.
- Trailer: the first trailer word loads at the first edge after the last data word leaves the output register (edge N+1 with no stall). The trailer words follow in consecutive cycles when out_ready = 1.
- Frame spacing: in_ready is 0 during TRL, giving a minimum gap of NTRL cycles between frames. The next frame's first word can be accepted in the cycle the last trailer word is handed off.
- Backpressure: out_ready = 0 freezes every output and the trailer index. No word is dropped or duplicated.
- Reset mid-frame or mid-trailer: the frame is abandoned, no further trailer words are emitted, and the output register clears.

## Test plan
- Single word 16'h0001 with first=last=1, out_ready=1 → frame_crc = 22'h000003. Output sequence: 16'h0001 (out_crc=0), 16'h0003 (out_crc=1), 16'h0000 (out_crc=1, out_last=1). crc_done pulses once.
- Two-word frame 16'h0001 then 16'h0000 → frame_crc = 22'h030000. Trailer words are 16'h0000 then 16'h0060.
- Same two-word frame with out_ready toggling 1,0,0,1,… → identical output sequence, outputs held during stalls, in_ready = 0 whenever out_valid & ~out_ready.
- Back-to-back frames: second frame's in_valid held high → in_ready low for exactly 2 cycles of trailer. Second frame_crc is independent of the first (INIT reseed).
- Framing errors:
  - Word without in_first in IDLE → err_sof pulse, CRC seeded from INIT.
  - in_first mid-frame → err_sof pulse, CRC equals a fresh frame from that word.
- Reset asserted during the trailer word 0 stall → next cycle out_valid = 0 and no out_last. A following frame 16'h0001 again gives 22'h000003.
